hires_fetch_sequencer: RTL

- Parametrised next-generation hires (80-column/bitmap) fetch engine on the dedicated video RAM.
- Once per phi cycle inside the hires fetch window, it runs a mode-dependent chain of 2–3 dependent RAM reads. Block-RAM read latency is a parameter, not a fixed 2 clocks.
- Staged results commit atomically to the pixel sequencer with a one-clock valid strobe.
- Adds a 64k bitmap mode and 16-bit pixel output.

---
 rtl/hires_fetch_sequencer.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/hires_fetch_sequencer.sv
// Hires (80-column / bitmap) video RAM fetch engine: one chained 2-3 read
// sequence per phi cycle inside the fetch window, committed atomically.
module hires_fetch_sequencer #(
  parameter int unsigned RAM_WIDTH   = 16,
  parameter int unsigned RAM_LATENCY = 2,
  parameter int unsigned WIN_START   = 14,
  parameter int unsigned WIN_END     = 54,
  parameter int unsigned ALTC_BIT    = 4
) (
  input  logic                 clk_dot4x,
  input  logic                 rst,
  input  logic                 clk_phi,
  input  logic [15:0]          phi_phase_start,
  input  logic [6:0]           cycle_num,
  input  logic [2:0]           char_pixel_base,
  input  logic [3:0]           matrix_base,
  input  logic [3:0]           color_base,
  input  logic [2:0]           rc,
  input  logic [10:0]          vc,
  input  logic [14:0]          fvc,
  input  logic                 char_case,
  input  logic [2:0]           hires_mode,
  output logic [RAM_WIDTH-1:0] video_mem_addr,
  input  logic [7:0]           video_mem_data,
  output logic [15:0]          pixel_data,
  output logic [7:0]           color_data,
  output logic                 fetch_valid,
  output logic                 busy
);

  localparam int unsigned CNT_W    = 2;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RAM_LATENCY - 1);
  localparam logic [6:0] WS        = 7'(WIN_START);
  localparam logic [6:0] WE        = 7'(WIN_END);
  localparam bit NARROW            = (RAM_WIDTH < 16);

  typedef enum logic {IDLE, FETCH} state_t;

  typedef struct packed {
    logic [2:0]  mode;
    logic [2:0]  cpb;
    logic [3:0]  mb;
    logic [3:0]  cb;
    logic [2:0]  rc;
    logic [10:0] vc;
    logic [14:0] fvc;
    logic        cc;
  } ctx_t;

  state_t             state, state_d;
  logic [1:0]         slot, slot_d;
  logic [CNT_W-1:0]   cnt, cnt_d;
  ctx_t               ctx_q, ctx_d, live;
  logic [7:0]         stage0, stage0_d, stage1, stage1_d;
  logic [RAM_WIDTH-1:0] addr_d;
  logic [15:0]        pix_d;
  logic [7:0]         col_d;
  logic               fv_d, busy_d, window, kick, last_slot;

  // Generated address for slot k; pure concatenation/OR, no carries.
  function automatic logic [15:0] slot_addr(input logic [1:0] k, input ctx_t c,
                                            input logic [7:0] s0, input logic [7:0] s1);
    logic [15:0] a;
    a = '0;
    case (c.mode)
      3'd0: begin
        if (k == 2'd0)      a = {1'b0, c.cb, c.vc};
        else if (k == 2'd1) a = {1'b0, c.mb, c.vc};
        else                a = {1'b0, c.cpb, c.cc | s0[ALTC_BIT], s1, c.rc};
      end
      3'd1:       a = (k == 2'd0) ? {1'b0, c.cb, c.vc} : {2'b00, c.fvc[14:1]};
      3'd2, 3'd3: a = (k == 2'd0) ? {1'b0, c.fvc} : {1'b0, c.fvc | 15'h0001};
      3'd4:       a = {c.fvc, k != 2'd0};
      default:    a = '0;
    endcase
    return a;
  endfunction

  always_comb begin
    live.mode = (hires_mode == 3'd4 && NARROW) ? 3'd2 : hires_mode;
    live.cpb  = char_pixel_base;
    live.mb   = matrix_base;
    live.cb   = color_base;
    live.rc   = rc;
    live.vc   = vc;
    live.fvc  = fvc;
    live.cc   = char_case;
  end

  assign window = (cycle_num == WS && clk_phi) ||
                  (cycle_num > WS && cycle_num < WE) ||
                  (cycle_num == WE && !clk_phi);
  assign kick   = window && phi_phase_start[2] && (state == IDLE) && (hires_mode <= 3'd4);

  always_comb begin
    state_d   = state;
    slot_d    = slot;
    cnt_d     = cnt;
    ctx_d     = ctx_q;
    stage0_d  = stage0;
    stage1_d  = stage1;
    addr_d    = video_mem_addr;
    pix_d     = pixel_data;
    col_d     = color_data;
    fv_d      = 1'b0;
    busy_d    = busy;
    last_slot = 1'b0;
    case (state)
      IDLE: begin
        if (kick) begin
          ctx_d   = live;
          slot_d  = 2'd0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          addr_d  = RAM_WIDTH'(slot_addr(2'd0, live, 8'h00, 8'h00));
          state_d = FETCH;
        end
      end
      FETCH: begin
        if (cnt == CNT_LAST) begin
          cnt_d = '0;
          if (slot == 2'd0) stage0_d = video_mem_data;
          if (slot == 2'd1) stage1_d = video_mem_data;
          last_slot = (ctx_q.mode == 3'd0) ? (slot == 2'd2) : (slot == 2'd1);
          if (last_slot) begin
            // Final capture edge: all outputs switch together.
            if (ctx_q.mode == 3'd0 || ctx_q.mode == 3'd1) begin
              col_d = stage0;
              pix_d = {8'h00, video_mem_data};
            end else begin
              pix_d = {stage0, video_mem_data};
            end
            fv_d    = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
          end else begin
            slot_d = slot + 2'd1;
            addr_d = RAM_WIDTH'(slot_addr(slot_d, ctx_q, stage0_d, stage1_d));
          end
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_dot4x or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      slot           <= '0;
      cnt            <= '0;
      ctx_q          <= '0;
      stage0         <= '0;
      stage1         <= '0;
      video_mem_addr <= '0;
      pixel_data     <= '0;
      color_data     <= '0;
      fetch_valid    <= 1'b0;
      busy           <= 1'b0;
    end else begin
      state          <= state_d;
      slot           <= slot_d;
      cnt            <= cnt_d;
      ctx_q          <= ctx_d;
      stage0         <= stage0_d;
      stage1         <= stage1_d;
      video_mem_addr <= addr_d;
      pixel_data     <= pix_d;
      color_data     <= col_d;
      fetch_valid    <= fv_d;
      busy           <= busy_d;
    end
  end

endmodule
